// File: rtl/layer_pkg.sv
// Shared types and fixed-point constants for the layer MAC scheduler.
// Includes the ReLU plus rescale applied to each neuron's final sum.
package layer_pkg;

  localparam int DW     = 32;
  localparam int FRAC   = 13;
  localparam int OUT_HI = 28;
  localparam int SW     = OUT_HI - FRAC + 1;

  typedef enum logic [1:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN
  } state_t;

  // Negative sums clamp to zero; positive sums are truncated, not saturated.
  function automatic logic [DW-1:0] relu_rescale(
    input logic [DW-1:0] sum
  );
    if (sum[DW-1])
      return '0;
    return {{(DW-SW){1'b0}}, sum[OUT_HI:FRAC]};
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Shared multiply-accumulate datapath.
// The accumulator is either loaded with a bias or accumulates one product per cycle.
module mac_unit
  import layer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          acc_en,
  input  logic [DW-1:0] bias,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] sum
);

  logic signed [DW-1:0] prod;
  logic        [DW-1:0] acc;

  assign prod = $signed(a) * $signed(w);
  assign sum  = acc + prod;

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (load)
      acc <= bias;
    else if (acc_en)
      acc <= sum;
  end

endmodule

// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed fully-connected layer: one MAC datapath walks every neuron,
// streaming one ReLU'd, rescaled result per neuron.
module layer_mac_scheduler
  import layer_pkg::*;
#(
  parameter int NUM_IN  = 15,
  parameter int NUM_OUT = 8,
  localparam int AW = $clog2(NUM_IN),
  localparam int WW = $clog2(NUM_IN*NUM_OUT),
  localparam int NW = $clog2(NUM_OUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] act_addr,
  input  logic [DW-1:0] act_data,
  output logic [WW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic [NW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          out_valid,
  output logic [NW-1:0] out_idx,
  output logic [DW-1:0] out_data
);

  state_t        state;
  logic [NW-1:0] n;
  logic [AW-1:0] i;
  logic [DW-1:0] sum;
  logic          load;
  logic          acc_en;

  assign load   = (state == MAC) && (i == '0);
  assign acc_en = (state == MAC) && (i != '0);

  mac_unit u_mac (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .acc_en (acc_en),
    .bias   (b_data),
    .a      (act_data),
    .w      (w_data),
    .sum    (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      n         <= '0;
      i         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      act_addr  <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state  <= BIAS;
            n      <= '0;
            b_addr <= '0;
          end
        end
        BIAS: begin
          state    <= MAC;
          i        <= '0;
          act_addr <= '0;
          // Weight rows are contiguous, so only the first neuron rewinds.
          w_addr   <= (n == '0) ? '0 : w_addr + WW'(1);
        end
        MAC: begin
          if (i == AW'(NUM_IN-1)) begin
            state <= DRAIN;
          end else begin
            i        <= i + AW'(1);
            act_addr <= i + AW'(1);
            w_addr   <= w_addr + WW'(1);
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_idx   <= n;
          out_data  <= relu_rescale(sum);
          if (n == NW'(NUM_OUT-1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            n      <= n + NW'(1);
            b_addr <= n + NW'(1);
            state  <= BIAS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Scoreboard bench for layer_mac_scheduler: expectations are queued at start,
// a negedge monitor checks every result strobe.
module tb_layer_mac_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  act_addr;
  logic [31:0] act_data;
  logic [6:0]  w_addr;
  logic [31:0] w_data;
  logic [2:0]  b_addr;
  logic [31:0] b_data;
  logic        out_valid;
  logic [2:0]  out_idx;
  logic [31:0] out_data;

  logic [31:0] act_mem [15];
  logic [31:0] w_mem   [120];
  logic [31:0] b_mem   [8];

  typedef struct {
    int cyc;
    int idx;
    int data;
    bit dn;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_pass;
  int   n_total;

  layer_mac_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .act_addr  (act_addr),
    .act_data  (act_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
    b_data   <= b_mem[b_addr];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected strobe", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe cycle", cyc, e.cyc);
        chk("out_idx", {29'b0, out_idx}, e.idx);
        chk("out_data", out_data, e.data);
        chk("done", {31'b0, done}, {31'b0, e.dn});
      end
    end else if (done) begin
      chk("done alone", {31'b0, done}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int sc, int cnt, int d[8]);
    for (int k = 0; k < cnt; k++) begin
      exp_t e;
      e.cyc  = sc + 18 + 17*k;
      e.idx  = k;
      e.data = d[k];
      e.dn   = (k == 7);
      q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && q.size() != 0; k++)
      step();
    repeat (5) step();
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic load_mem(int w, int bias);
    for (int k = 0; k < 120; k++) w_mem[k] = w;
    for (int k = 0; k < 8; k++) b_mem[k] = bias;
  endtask

  initial begin
    int dv[8];
    int sc;
    cyc     = 0;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    start   = 1'b0;
    for (int k = 0; k < 15; k++) act_mem[k] = 32'd8192;
    load_mem(0, 24576);
    repeat (3) step();
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_idx", {29'b0, out_idx}, 32'd0);
    chk("rst addr", {17'b0, act_addr, w_addr, b_addr}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Timing: every neuron yields 3, second start at cycle 50 ignored.
    start = 1'b1;
    sc = cyc;
    dv = '{3, 3, 3, 3, 3, 3, 3, 3};
    push(sc, 8, dv);
    @(negedge clk);
    chk("busy c0", {31'b0, busy}, 32'd0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("busy c1", {31'b0, busy}, 32'd1);
    while (cyc < sc + 50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < sc + 137) step();
    @(negedge clk);
    chk("busy c137", {31'b0, busy}, 32'd1);
    step();
    @(negedge clk);
    chk("busy c138", {31'b0, busy}, 32'd0);
    wait_drain();

    // Small bias rescales to zero.
    load_mem(0, 200);
    step();
    start = 1'b1;
    sc = cyc;
    dv = '{0, 0, 0, 0, 0, 0, 0, 0};
    push(sc, 8, dv);
    step();
    start = 1'b0;
    wait_drain();

    // Truncation on neuron 0, ReLU on neuron 1, bias-only elsewhere.
    load_mem(0, 0);
    for (int k = 0; k < 15; k++) w_mem[k] = 32'd8192;
    for (int k = 15; k < 30; k++) w_mem[k] = -32'sd8192;
    b_mem[1] = 32'd4096;
    for (int k = 2; k < 8; k++) b_mem[k] = k * 8192;
    step();
    start = 1'b1;
    sc = cyc;
    dv = '{57344, 0, 2, 3, 4, 5, 6, 7};
    push(sc, 8, dv);
    step();
    start = 1'b0;
    wait_drain();

    // Abort with reset at cycle 40, then a clean restart.
    start = 1'b1;
    sc = cyc;
    push(sc, 2, dv);
    step();
    start = 1'b0;
    while (cyc < sc + 40) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort out_data", out_data, 32'd0);
    chk("abort out_idx", {29'b0, out_idx}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort queue", q.size(), 32'd0);
    step();
    start = 1'b1;
    sc = cyc;
    push(sc, 8, dv);
    step();
    start = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/layer_mac_scheduler.md
Name: layer_mac_scheduler

Overview:
Time-multiplexed controller for one fully-connected layer. A single shared multiply-accumulate datapath evaluates NUM_OUT neurons one after another, instead of one parallel node per neuron. Each neuron has NUM_IN inputs, Q-format weights and a bias. The block sequences weight/bias ROM and activation-buffer reads, accumulates, applies ReLU plus fixed-point rescale, and streams one result per neuron. It sits between a layer's activation buffer and the next layer's input buffer.

Parameters:
NUM_IN, 15, inputs per neuron
NUM_OUT, 8, neurons in the layer
DW, 32, data/weight/accumulator width
FRAC, 13, fractional bits; result slice low bit
OUT_HI, 28, result slice high bit (slice width OUT_HI-FRAC+1 = 16)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request one full layer evaluation; sampled only in IDLE
busy  out  1  high from first cycle after accepted start through done cycle
done  out  1  one-cycle pulse, coincident with last out_valid
act_addr  out  clog2(NUM_IN)  activation buffer read address
act_data  in  DW  activation read data, 1-cycle latency
w_addr  out  clog2(NUM_IN*NUM_OUT)  weight ROM address = n*NUM_IN+i
w_data  in  DW  signed weight, 1-cycle latency
b_addr  out  clog2(NUM_OUT)  bias ROM address = n
b_data  in  DW  signed bias, 1-cycle latency
out_valid  out  1  one-cycle strobe per neuron result
out_idx  out  clog2(NUM_OUT)  neuron index of out_data
out_data  out  DW  ReLU'd, rescaled result, zero-extended

Behaviour:
- Reset sets state=IDLE and clears n, i and acc. It also clears busy, done, out_valid, out_idx and out_data, plus all addresses. Reset mid-evaluation aborts with no done pulse; partial results are discarded.
- FSM states: IDLE, BIAS, MAC, DRAIN.
- IDLE: start=1 -> BIAS with n=0. The start cycle is cycle 0.
- BIAS (1 cycle): drive b_addr=n -> MAC with i=0.
- MAC (NUM_IN cycles): drive act_addr=i and w_addr=n*NUM_IN+i, then i++.
  - First MAC cycle: acc <= b_data.
  - Later MAC cycles: acc <= acc + act_data*w_data from the previous issue.
  - When i==NUM_IN-1 -> DRAIN.
- DRAIN (1 cycle): the final sum is acc + last product. At the edge ending DRAIN, register the outputs:
  - out_valid=1 and out_idx=n.
  - out_data = 0 if sum[DW-1]==1; otherwise zero-extend sum[OUT_HI:FRAC]. Upper bits above the slice are truncated, not saturated.
  - If n==NUM_OUT-1: done=1 and go to IDLE. Otherwise n++ and go to BIAS.
- Arithmetic: signed DW x DW multiply, keep low DW bits; accumulate modulo 2^DW, no saturation.
- Timing with defaults: 17 cycles per neuron. Neuron n out_valid falls at cycle 18+17n: neuron 0 at cycle 18, neuron 7 at cycle 137, with done also at 137. busy is high for cycles 1..137.
- out_valid and done are high for exactly one cycle. out_data and out_idx hold their value until the next strobe.
- start while busy is ignored, with no queuing. start held high continuously restarts in the cycle after done returns the FSM to IDLE.
- Addresses hold their last value outside BIAS/MAC.

Decomposition:
- Shared package layer_pkg holds:
  - state enum;
  - DW, FRAC and OUT_HI defaults;
  - function relu_rescale(sum) returning DW bits.
- One sub-module, mac_unit. It contains the signed multiply, the acc register, a load-bias control and an accumulate enable. The FSM, counters and output registers stay in the top level.

Test Plan:
- Timing: weights 0, all biases 24576 (3.0), pulse start at cycle 0 -> out_valid at cycles 18,35,...,137; out_idx 0..7; out_data=3 each; done only at 137; busy cycles 1..137.
- Small bias: weights 0, bias 200 -> out_data=0 for all neurons (200>>13=0).
- Truncation: activations all 8192, neuron 0 weights all 8192, bias 0 -> sum=15*2^26, out_data=122880 mod 65536=57344.
- ReLU: neuron 1 weights all -8192, activations 8192, bias 4096 -> sum negative -> out_data=0, out_idx=1.
- start pulsed again at cycle 50 -> ignored; exactly 8 strobes and one done.
- Abort and restart: reset at cycle 40 -> all outputs 0 next cycle, no done. A new start then yields first out_valid 18 cycles after the start cycle with correct data.
